// File: rtl/ifetch.sv
// Instruction fetch stage: holds the PC, issues one icache request at a time,
// predecodes returned instructions to pick the next PC and buffers them for decode.
module ifetch #(
  parameter int unsigned IQ_DEPTH = 8,
  parameter int unsigned BHT_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic [31:0] IC_addr,
  output logic        IC_addr_sgn,
  input  logic [31:0] IC_val,
  input  logic        IC_val_sgn,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc,
  output logic        ID_pred,
  output logic        ID_sgn,
  input  logic        ID_ready,
  input  logic        RB_clear,
  input  logic [31:0] RB_pc,
  input  logic        BP_upd,
  input  logic [31:0] BP_pc,
  input  logic        BP_taken
);

  localparam int unsigned PtrW    = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned BhtSize = 1 << BHT_BITS;

  typedef enum logic [1:0] {StReq, StWait, StGap} state_e;

  state_e                       state_q;
  logic [31:0]                  pc_q;
  logic [PtrW-1:0]              head_q, tail_q;
  logic [CntW-1:0]              count_q;
  logic [IQ_DEPTH-1:0][31:0]    iq_inst_q;
  logic [IQ_DEPTH-1:0][31:0]    iq_pc_q;
  logic [IQ_DEPTH-1:0]          iq_pred_q;
  logic [BhtSize-1:0][1:0]      bht_q;

  logic                fifo_full, push, pop;
  logic [31:0]         imm_j, imm_b, next_pc;
  logic                pred;
  logic [BHT_BITS-1:0] fetch_idx, upd_idx;
  logic                unused_bp_pc;

  assign fifo_full = (count_q == CntW'(IQ_DEPTH));
  assign IC_addr   = pc_q;
  assign ID_sgn    = (count_q != '0);
  assign ID_inst   = iq_inst_q[head_q];
  assign ID_pc     = iq_pc_q[head_q];
  assign ID_pred   = iq_pred_q[head_q];

  // A redirect discards both the returning response and any pop in the same cycle.
  assign push = rdy && !RB_clear && (state_q == StWait) && IC_val_sgn;
  assign pop  = rdy && !RB_clear && ID_sgn && ID_ready;

  assign fetch_idx    = pc_q[BHT_BITS+1:2];
  assign upd_idx      = BP_pc[BHT_BITS+1:2];
  assign unused_bp_pc = ^{BP_pc[31:BHT_BITS+2], BP_pc[1:0]};

  assign imm_j = {{11{IC_val[31]}}, IC_val[31], IC_val[19:12], IC_val[20], IC_val[30:21], 1'b0};
  assign imm_b = {{19{IC_val[31]}}, IC_val[31], IC_val[7], IC_val[30:25], IC_val[11:8], 1'b0};

  // Request strobe: REQ only when a FIFO slot is free, held through WAIT, low in GAP.
  always_comb begin
    IC_addr_sgn = 1'b0;
    if (rst && rdy) begin
      case (state_q)
        StReq:   IC_addr_sgn = !fifo_full;
        StWait:  IC_addr_sgn = 1'b1;
        default: IC_addr_sgn = 1'b0;
      endcase
    end
  end

  // Predecode: JAL always taken, conditional branches follow the BHT counter MSB.
  always_comb begin
    next_pc = pc_q + 32'd4;
    pred    = 1'b0;
    if (IC_val[6:0] == 7'b1101111) begin
      next_pc = pc_q + imm_j;
      pred    = 1'b1;
    end else if ((IC_val[6:0] == 7'b1100011) && bht_q[fetch_idx][1]) begin
      next_pc = pc_q + imm_b;
      pred    = 1'b1;
    end
  end

  // Fetch FSM, PC and FIFO pointers/count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (RB_clear) begin
        pc_q    <= RB_pc;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        state_q <= StGap;
      end else begin
        if (push) tail_q <= tail_q + 1'b1;
        if (pop)  head_q <= head_q + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        case (state_q)
          StReq:   if (IC_addr_sgn) state_q <= StWait;
          StWait: begin
            if (IC_val_sgn) begin
              pc_q    <= next_pc;
              state_q <= StGap;
            end
          end
          // The cycle after a response may carry a stale hit for the old PC; skip it.
          StGap:   state_q <= StReq;
          default: state_q <= StReq;
        endcase
      end
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      iq_inst_q[tail_q] <= IC_val;
      iq_pc_q[tail_q]   <= pc_q;
      iq_pred_q[tail_q] <= pred;
    end
  end

  // Branch history: 2-bit saturating counters, lookups see the pre-update value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bht_q <= {BhtSize{2'b01}};
    end else if (rdy && BP_upd) begin
      if (BP_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: acts as the icache/decoder/ROB and checks against a
// transaction-level model (expected instruction queue, PC stream, counter table).
module tb_ifetch;
  localparam int unsigned IQ_DEPTH = 8;
  localparam int unsigned BHT_BITS = 6;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [31:0] IC_addr;
  logic        IC_addr_sgn;
  logic [31:0] IC_val;
  logic        IC_val_sgn;
  logic [31:0] ID_inst, ID_pc;
  logic        ID_pred, ID_sgn, ID_ready, RB_clear;
  logic [31:0] RB_pc;
  logic        BP_upd;
  logic [31:0] BP_pc;
  logic        BP_taken;

  always #5 clk = ~clk;

  ifetch #(.IQ_DEPTH(IQ_DEPTH), .BHT_BITS(BHT_BITS), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .IC_addr(IC_addr), .IC_addr_sgn(IC_addr_sgn),
    .IC_val(IC_val), .IC_val_sgn(IC_val_sgn), .ID_inst(ID_inst), .ID_pc(ID_pc),
    .ID_pred(ID_pred), .ID_sgn(ID_sgn), .ID_ready(ID_ready), .RB_clear(RB_clear),
    .RB_pc(RB_pc), .BP_upd(BP_upd), .BP_pc(BP_pc), .BP_taken(BP_taken)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  int errors = 0;
  int checks = 0;

  // Program image: raw word plus the intended control-flow kind and offset.
  logic [31:0] mem_inst [int unsigned];
  int          mem_kind [int unsigned];  // 0 sequential, 1 jal, 2 conditional branch
  int          mem_off  [int unsigned];
  int          bhtm [1 << BHT_BITS];

  ent_t        exp_q[$];
  ent_t        pop_log[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];

  logic [31:0] mpc;
  logic [31:0] req_addr;
  bit          outst, gap_pend, req_due;
  int          wait_ctr, cyc, clr_cyc;
  bit          rnd_mode, clear_on_resp;
  int          lat_min, lat_max;
  logic        f_rdy, f_id_ready, f_bp, f_bp_taken, f_clear;
  logic [31:0] f_bp_pc, f_clear_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] imm;
    imm = off[20:0];
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input int off);
    logic [12:0] imm;
    imm = off[12:0];
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic set_prog(input int unsigned a, input logic [31:0] i, input int k, input int o);
    mem_inst[a] = i;
    mem_kind[a] = k;
    mem_off[a]  = o;
  endtask

  function automatic int bidx(input logic [31:0] a);
    return int'((a >> 2) % (1 << BHT_BITS));
  endfunction

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic cycle();
    ent_t        e;
    logic [31:0] a;
    int          k, off;
    bit          was_gap, do_req, exp_sgn;
    @(negedge clk);
    cyc++;
    if (rnd_mode) begin
      rdy      = ($urandom_range(7) != 0);
      ID_ready = 1'($urandom_range(1));
      BP_upd   = ($urandom_range(3) == 0);
      BP_pc    = 32'($urandom_range(63)) << 2;
      BP_taken = 1'($urandom_range(1));
      RB_clear = ($urandom_range(39) == 0);
      RB_pc    = 32'($urandom_range(63)) << 2;
    end else begin
      rdy = f_rdy; ID_ready = f_id_ready; BP_upd = f_bp; BP_pc = f_bp_pc;
      BP_taken = f_bp_taken; RB_clear = f_clear; RB_pc = f_clear_pc;
    end
    IC_val_sgn = 1'b0;
    IC_val     = $urandom();
    if (outst && wait_ctr == 0) begin
      IC_val_sgn = 1'b1;
      IC_val     = mem_inst.exists(req_addr) ? mem_inst[req_addr] : 32'h0000_0013;
      if (clear_on_resp && rdy) begin
        RB_clear = 1'b1; RB_pc = 32'h100; clear_on_resp = 1'b0; clr_cyc = cyc;
      end
    end else if (gap_pend && rnd_mode && $urandom_range(1) == 1) begin
      IC_val_sgn = 1'b1;
    end
    #1;
    exp_sgn = rdy && (outst || (!gap_pend && req_due && exp_q.size() < IQ_DEPTH));
    chk("ic_addr_sgn", 32'(IC_addr_sgn), 32'(exp_sgn));
    chk("ic_addr", IC_addr, mpc);
    chk("id_sgn", 32'(ID_sgn), 32'(exp_q.size() != 0));
    if (rdy && !RB_clear && !outst && !gap_pend && IC_addr_sgn === 1'b1) begin
      req_log.push_back(IC_addr);
      req_cyc.push_back(cyc);
    end
    if (rdy) begin
      was_gap = gap_pend;
      do_req  = !outst && !gap_pend && req_due && (exp_q.size() < IQ_DEPTH);
      if (RB_clear) begin
        exp_q.delete();
        mpc = RB_pc; outst = 1'b0; gap_pend = 1'b1; req_due = 1'b0;
      end else begin
        if (exp_q.size() != 0 && ID_ready) begin
          chk("pop_inst", ID_inst, exp_q[0].inst);
          chk("pop_pc", ID_pc, exp_q[0].pc);
          chk("pop_pred", 32'(ID_pred), 32'(exp_q[0].pred));
          e.inst = ID_inst; e.pc = ID_pc; e.pred = ID_pred;
          pop_log.push_back(e);
          void'(exp_q.pop_front());
        end
        if (outst && IC_val_sgn) begin
          a   = req_addr;
          k   = mem_kind.exists(a) ? mem_kind[a] : 0;
          off = mem_off.exists(a) ? mem_off[a] : 0;
          e.inst = IC_val; e.pc = a; e.pred = 1'b0;
          mpc = a + 32'd4;
          if (k == 1 || (k == 2 && bhtm[bidx(a)] >= 2)) begin
            mpc = a + 32'(off); e.pred = 1'b1;
          end
          exp_q.push_back(e);
          outst = 1'b0; gap_pend = 1'b1; req_due = 1'b0;
        end else if (do_req) begin
          outst = 1'b1; req_addr = mpc; req_due = 1'b0;
          wait_ctr = lat_min + int'($urandom_range(lat_max - lat_min));
        end else if (outst && wait_ctr > 0) begin
          wait_ctr--;
        end
        if (was_gap) begin
          gap_pend = 1'b0; req_due = 1'b1;
        end
      end
      if (BP_upd) begin
        k = bidx(BP_pc);
        if (BP_taken) begin
          if (bhtm[k] < 3) bhtm[k]++;
        end else if (bhtm[k] > 0) begin
          bhtm[k]--;
        end
      end
    end
  endtask

  task automatic run_until_reqs(input int n, input int budget, input string tag);
    int k = 0;
    while (req_log.size() < n && k < budget) begin cycle(); k++; end
    chk(tag, 32'(req_log.size() >= n), 32'd1);
  endtask

  task automatic run_until_pops(input int n, input int budget, input string tag);
    int k = 0;
    while (pop_log.size() < n && k < budget) begin cycle(); k++; end
    chk(tag, 32'(pop_log.size() >= n), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] target);
    f_clear = 1'b1; f_clear_pc = target;
    cycle();
    clr_cyc = cyc;
    f_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, pbase, r, o;
    foreach (bhtm[i]) bhtm[i] = 1;
    mpc = RESET_PC; outst = 0; gap_pend = 0; req_due = 1; wait_ctr = 0; cyc = 0; clr_cyc = 0;
    rnd_mode = 0; clear_on_resp = 0; lat_min = 0; lat_max = 0;
    f_rdy = 1; f_id_ready = 1; f_bp = 0; f_bp_taken = 0; f_clear = 0;
    f_bp_pc = '0; f_clear_pc = '0;
    rst = 0; rdy = 1; ID_ready = 1; RB_clear = 0; RB_pc = '0; BP_upd = 0; BP_pc = '0;
    BP_taken = 0; IC_val = '0; IC_val_sgn = 0;

    // Reset state
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_addr_sgn", 32'(IC_addr_sgn), 32'd0);
      chk("rst_id_sgn", 32'(ID_sgn), 32'd0);
      chk("rst_pc", IC_addr, RESET_PC);
    end
    @(posedge clk); #2 rst = 1;

    // Sequential addi stream, then JAL +8 at 0x10
    set_prog(32'h10, 32'h0080006F, 1, 8);
    run_until_reqs(6, 60, "seq_reqs");
    chk("seq_req0", req_log[0], 32'h0);
    chk("seq_req1", req_log[1], 32'h4);
    chk("seq_req2", req_log[2], 32'h8);
    chk("seq_req4", req_log[4], 32'h10);
    chk("jal_fwd_target", req_log[5], 32'h18);
    chk("seq_period", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
    chk("seq_period2", 32'(req_cyc[2] - req_cyc[1]), 32'd3);
    chk("seq_pop_pc1", pop_log[1].pc, 32'h4);
    chk("seq_pop_pred0", 32'(pop_log[0].pred), 32'd0);
    chk("jal_pop_inst", pop_log[4].inst, 32'h0080006F);
    chk("jal_pop_pred", 32'(pop_log[4].pred), 32'd1);

    // Backward JAL at 0x10
    set_prog(32'h10, 32'hFFDFF06F, 1, -4);
    base = req_log.size();
    redirect(32'h10);
    run_until_reqs(base + 2, 30, "jal_back_reqs");
    chk("redir_req", req_log[base], 32'h10);
    chk("redir_latency", 32'(req_cyc[base] - clr_cyc), 32'd2);
    chk("jal_back_target", req_log[base + 1], 32'hC);

    // BEQ +8 at 0x20: not taken from reset, taken after two taken updates
    set_prog(32'h20, 32'h00000463, 2, 8);
    base = req_log.size();
    redirect(32'h20);
    run_until_reqs(base + 2, 30, "br_nt_reqs");
    chk("br_nt_next", req_log[base + 1], 32'h24);
    chk("br_nt_pred", 32'(pop_log[pop_log.size() - 1].pred), 32'd0);
    f_bp = 1; f_bp_pc = 32'h20; f_bp_taken = 1;
    repeat (2) cycle();
    f_bp = 0;
    base = req_log.size();
    redirect(32'h20);
    run_until_reqs(base + 2, 30, "br_t_reqs");
    chk("br_t_next", req_log[base + 1], 32'h28);
    chk("br_t_pred", 32'(pop_log[pop_log.size() - 1].pred), 32'd1);

    // Fill the FIFO with the decoder stalled, then free one slot
    f_id_ready = 0;
    base = req_log.size();
    redirect(32'h40);
    repeat (40) cycle();
    chk("full_reqs", 32'(req_log.size() - base), IQ_DEPTH);
    chk("full_id_sgn", 32'(ID_sgn), 32'd1);
    base = req_log.size();
    f_id_ready = 1; cycle(); f_id_ready = 0;
    repeat (10) cycle();
    chk("one_pop_one_req", 32'(req_log.size() - base), 32'd1);

    // Redirect in the same cycle as a hit response
    base = req_log.size();
    clear_on_resp = 1;
    f_id_ready = 1; cycle(); f_id_ready = 0;
    run_until_reqs(base + 2, 30, "clr_resp_reqs");
    chk("clr_resp_target", req_log[base + 1], 32'h100);
    chk("clr_resp_latency", 32'(req_cyc[base + 1] - clr_cyc), 32'd2);

    // rdy low for 5 cycles during a miss
    lat_min = 12; lat_max = 12; f_id_ready = 1;
    base = req_log.size();
    redirect(32'h200);
    run_until_reqs(base + 1, 10, "miss_req");
    repeat (2) cycle();
    f_rdy = 0;
    repeat (5) begin
      cycle();
      chk("frozen_addr", IC_addr, 32'h200);
    end
    f_rdy = 1;
    pbase = pop_log.size();
    run_until_pops(pbase + 1, 40, "miss_pop");
    chk("miss_pop_pc", pop_log[pbase].pc, 32'h200);
    chk("miss_single_req", 32'(req_log.size() - base), 32'd1);

    // Randomized traffic over a random program
    for (int unsigned a = 0; a < 32'h100; a += 4) begin
      r = int'($urandom_range(9));
      o = (int'($urandom_range(16)) - 8) * 4;
      if (r < 5)       set_prog(a, 32'h0000_0013, 0, 0);
      else if (r == 5) set_prog(a, 32'h0000_8067, 0, 0);
      else if (r < 8)  set_prog(a, enc_jal(o), 1, o);
      else             set_prog(a, enc_br(o), 2, o);
    end
    lat_min = 0; lat_max = 3;
    rnd_mode = 1;
    repeat (2000) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
